// File: rtl/mc_core_mk2_if.sv
// Program loader port for mc_core_mk2: valid/ready word stream with a last-word marker.
interface mc_core_mk2_if #(
  parameter int unsigned DATA_W = 8
);
  localparam int unsigned IW = 4 + DATA_W;

  logic          prog_valid;
  logic          prog_ready;
  logic [IW-1:0] prog_data;
  logic          prog_last;

  modport master (output prog_valid, output prog_data, output prog_last, input prog_ready);
  modport slave  (input prog_valid, input prog_data, input prog_last, output prog_ready);
endinterface

// File: rtl/mc_core_mk2.sv
// Multicycle accumulator core: streamed program load, FETCH/DECODE/EXECUTE, flags, OUT port, HALT.
// Optional single-step gating via macro MC_STEP_EN (adds the step port and a PAUSE state).
module mc_core_mk2 #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned PMEM_DEPTH = 16,
  parameter int unsigned DMEM_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
`ifdef MC_STEP_EN
  input  logic                          step,
`endif
  mc_core_mk2_if.slave                  prog,
  output logic [DATA_W-1:0]             out_data,
  output logic                          out_valid,
  output logic                          halted,
  output logic [$clog2(PMEM_DEPTH)-1:0] pc_dbg
);
  localparam int unsigned IW   = 4 + DATA_W;
  localparam int unsigned PA_W = $clog2(PMEM_DEPTH);
  localparam int unsigned DA_W = $clog2(DMEM_DEPTH);

  localparam logic [3:0] OP_LDI  = 4'h1, OP_LD   = 4'h2, OP_ST  = 4'h3, OP_ADD = 4'h4;
  localparam logic [3:0] OP_SUB  = 4'h5, OP_AND  = 4'h6, OP_OR  = 4'h7, OP_XOR = 4'h8;
  localparam logic [3:0] OP_ADDI = 4'h9, OP_JMP  = 4'hA, OP_JZ  = 4'hB, OP_JC  = 4'hC;
  localparam logic [3:0] OP_SHR  = 4'hD, OP_OUT  = 4'hE, OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    S_LOAD = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXECUTE = 3'd3, S_HALT = 3'd4, S_PAUSE = 3'd5
  } state_e;

  state_e              state_q, state_d;
  logic [PA_W-1:0]     load_addr_q, load_addr_d;
  logic [PA_W-1:0]     pc_q, pc_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic                z_q, z_d, c_q, c_d;
  logic [IW-1:0]       ir_q, ir_d;
  logic [DATA_W-1:0]   dr_q, dr_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;
  logic                halted_q, halted_d;
  logic                pmem_we, dmem_we, acc_wr;

  logic [IW-1:0]       pmem_q [PMEM_DEPTH];
  logic [DATA_W-1:0]   dmem_q [DMEM_DEPTH];

  logic [3:0]          op_c;
  logic [DATA_W-1:0]   opnd_c;
  logic [DATA_W:0]     sum_c, diff_c;
  logic                handshake_c, load_done_c, step_go_c;

  assign op_c        = ir_q[IW-1:DATA_W];
  assign opnd_c      = ir_q[DATA_W-1:0];
  assign sum_c       = {1'b0, acc_q} + {1'b0, (op_c == OP_ADDI) ? opnd_c : dr_q};
  assign diff_c      = {1'b0, acc_q} - {1'b0, dr_q};
  assign prog.prog_ready = rst && (state_q == S_LOAD);
  assign handshake_c = prog.prog_valid && prog.prog_ready;
  assign load_done_c = handshake_c && (prog.prog_last || (load_addr_q == PA_W'(PMEM_DEPTH - 1)));
`ifdef MC_STEP_EN
  assign step_go_c   = step;
`else
  assign step_go_c   = 1'b1;
`endif

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign halted    = halted_q;
  assign pc_dbg    = pc_q;

  // State and datapath registers; reset overrides everything.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_LOAD;
      load_addr_q <= '0;
      pc_q        <= '0;
      acc_q       <= '0;
      z_q         <= 1'b0;
      c_q         <= 1'b0;
      ir_q        <= '0;
      dr_q        <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      load_addr_q <= load_addr_d;
      pc_q        <= pc_d;
      acc_q       <= acc_d;
      z_q         <= z_d;
      c_q         <= c_d;
      ir_q        <= ir_d;
      dr_q        <= dr_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      halted_q    <= halted_d;
    end
  end

  // Memories survive reset; a write coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (pmem_we) pmem_q[load_addr_q] <= prog.prog_data;
      if (dmem_we) dmem_q[opnd_c[DA_W-1:0]] <= acc_q;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_LOAD:    if (load_done_c) state_d = S_FETCH;
      S_FETCH:   state_d = S_DECODE;
      S_DECODE:  state_d = S_EXECUTE;
      S_EXECUTE: begin
        if (op_c == OP_HALT) state_d = S_HALT;
        else if (step_go_c)  state_d = S_FETCH;
        else                 state_d = S_PAUSE;
      end
      S_HALT:    state_d = S_HALT;
      S_PAUSE:   if (step_go_c) state_d = S_FETCH;
      default:   state_d = S_LOAD;
    endcase
  end

  // Datapath and output logic.
  always_comb begin
    load_addr_d = load_addr_q;
    pc_d        = pc_q;
    acc_d       = acc_q;
    z_d         = z_q;
    c_d         = c_q;
    ir_d        = ir_q;
    dr_d        = dr_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    halted_d    = halted_q;
    pmem_we     = 1'b0;
    dmem_we     = 1'b0;
    acc_wr      = 1'b0;
    unique case (state_q)
      S_LOAD: begin
        if (handshake_c) begin
          pmem_we     = 1'b1;
          load_addr_d = load_addr_q + PA_W'(1);
        end
        if (load_done_c) begin
          load_addr_d = '0;
          pc_d        = '0;
          acc_d       = '0;
          z_d         = 1'b0;
          c_d         = 1'b0;
          ir_d        = '0;
          dr_d        = '0;
        end
      end
      S_FETCH:  ir_d = pmem_q[pc_q];
      S_DECODE: dr_d = dmem_q[opnd_c[DA_W-1:0]];
      S_EXECUTE: begin
        pc_d = pc_q + PA_W'(1);
        unique case (op_c)
          OP_LDI:  begin acc_d = opnd_c;          acc_wr = 1'b1; end
          OP_LD:   begin acc_d = dr_q;            acc_wr = 1'b1; end
          OP_ST:   dmem_we = 1'b1;
          OP_ADD, OP_ADDI: begin
            acc_d = sum_c[DATA_W-1:0]; c_d = sum_c[DATA_W]; acc_wr = 1'b1;
          end
          OP_SUB:  begin acc_d = diff_c[DATA_W-1:0]; c_d = diff_c[DATA_W]; acc_wr = 1'b1; end
          OP_AND:  begin acc_d = acc_q & dr_q; c_d = 1'b0; acc_wr = 1'b1; end
          OP_OR:   begin acc_d = acc_q | dr_q; c_d = 1'b0; acc_wr = 1'b1; end
          OP_XOR:  begin acc_d = acc_q ^ dr_q; c_d = 1'b0; acc_wr = 1'b1; end
          OP_JMP:  pc_d = opnd_c[PA_W-1:0];
          OP_JZ:   if (z_q) pc_d = opnd_c[PA_W-1:0];
          OP_JC:   if (c_q) pc_d = opnd_c[PA_W-1:0];
          OP_SHR:  begin acc_d = acc_q >> 1; c_d = acc_q[0]; acc_wr = 1'b1; end
          OP_OUT:  begin out_data_d = acc_q; out_valid_d = 1'b1; end
          OP_HALT: begin pc_d = pc_q; halted_d = 1'b1; end
          default: ;
        endcase
        if (acc_wr) z_d = (acc_d == '0);
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_mc_core_mk2.sv
// Directed bench for mc_core_mk2 with hand-computed expectations (default parameters).
module tb_mc_core_mk2;
  logic       clk = 1'b0;
  logic       rst;
  logic       step;
  logic [7:0] out_data;
  logic       out_valid;
  logic       halted;
  logic [3:0] pc_dbg;

  int n_vec = 0;
  int n_err = 0;
  logic [11:0] prog_mem [16];

  mc_core_mk2_if #(.DATA_W(8)) prog_if ();

  mc_core_mk2 #(.DATA_W(8), .PMEM_DEPTH(16), .DMEM_DEPTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef MC_STEP_EN
    .step      (step),
`endif
    .prog      (prog_if.slave),
    .out_data  (out_data),
    .out_valid (out_valid),
    .halted    (halted),
    .pc_dbg    (pc_dbg)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b0;
    prog_if.prog_valid = 1'b0;
    prog_if.prog_last  = 1'b0;
    prog_if.prog_data  = '0;
    tick();
    tick();
    rst = 1'b1;
    #1;
  endtask

  task automatic load_prog(input int len);
    for (int i = 0; i < len; i++) begin
      int t = 0;
      prog_if.prog_valid = 1'b1;
      prog_if.prog_data  = prog_mem[i];
      prog_if.prog_last  = (i == len - 1);
      while (!prog_if.prog_ready && t < 20) begin
        tick();
        t++;
      end
      if (t >= 20) begin
        n_vec++; n_err++;
        $display("FAIL load_ready word %0d: ready=%0b required=1", i, prog_if.prog_ready);
      end
      tick();
    end
    prog_if.prog_valid = 1'b0;
    prog_if.prog_last  = 1'b0;
  endtask

  task automatic run_to_halt(input int budget, output int pulses, output logic [7:0] last_out);
    int c = 0;
    pulses = 0;
    last_out = '0;
    while (!halted && c < budget) begin
      tick();
      c++;
      if (out_valid) begin
        pulses++;
        last_out = out_data;
      end
    end
    n_vec++;
    if (halted !== 1'b1) begin
      n_err++;
      $display("FAIL halt_timeout: halted=%0b required=1 after %0d cycles", halted, c);
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    step = 1'b1;
    prog_if.prog_valid = 1'b0;
    prog_if.prog_last  = 1'b0;
    prog_if.prog_data  = '0;
    tick();
    tick();
    n_vec++; if (pc_dbg !== 4'd0) begin n_err++; $display("FAIL rst_pc: got %0d want 0", pc_dbg); end
    n_vec++; if (halted !== 1'b0) begin n_err++; $display("FAIL rst_halted: got %0b want 0", halted); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %0b want 0", out_valid); end
    n_vec++; if (out_data !== 8'h00) begin n_err++; $display("FAIL rst_out_data: got %h want 00", out_data); end
    n_vec++; if (prog_if.prog_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready_low: got %0b want 0", prog_if.prog_ready); end
    rst = 1'b1;
    #1;
    n_vec++; if (prog_if.prog_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready_high: got %0b want 1", prog_if.prog_ready); end
  endtask

  task automatic test_arith;
    int rise = 0;
    do_reset();
    prog_mem[0] = 12'h105; prog_mem[1] = 12'h9FF; prog_mem[2] = 12'hF00;
    load_prog(3);
    n_vec++; if (dut.state_q !== 3'd1) begin n_err++; $display("FAIL arith_fetch_start: state %0d want 1", dut.state_q); end
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (halted && rise == 0) rise = i;
    end
    n_vec++; if (rise !== 9) begin n_err++; $display("FAIL arith_halt_latency: got %0d want 9", rise); end
    n_vec++; if (dut.acc_q !== 8'h04) begin n_err++; $display("FAIL arith_acc: got %h want 04", dut.acc_q); end
    n_vec++; if (dut.c_q !== 1'b1) begin n_err++; $display("FAIL arith_c: got %0b want 1", dut.c_q); end
    n_vec++; if (dut.z_q !== 1'b0) begin n_err++; $display("FAIL arith_z: got %0b want 0", dut.z_q); end
    n_vec++; if (pc_dbg !== 4'd2) begin n_err++; $display("FAIL arith_pc: got %0d want 2", pc_dbg); end
  endtask

  task automatic test_store_out;
    int pulses;
    logic [7:0] last_out;
    do_reset();
    prog_mem[0] = 12'h13C; prog_mem[1] = 12'h302; prog_mem[2] = 12'h100;
    prog_mem[3] = 12'h202; prog_mem[4] = 12'hE00; prog_mem[5] = 12'hF00;
    load_prog(6);
    run_to_halt(60, pulses, last_out);
    n_vec++; if (pulses !== 1) begin n_err++; $display("FAIL st_out_pulses: got %0d want 1", pulses); end
    n_vec++; if (last_out !== 8'h3C) begin n_err++; $display("FAIL st_out_data: got %h want 3c", last_out); end
    n_vec++; if (dut.z_q !== 1'b0) begin n_err++; $display("FAIL st_z_after_ld: got %0b want 0", dut.z_q); end
    n_vec++; if (dut.dmem_q[2] !== 8'h3C) begin n_err++; $display("FAIL st_dmem2: got %h want 3c", dut.dmem_q[2]); end
  endtask

  task automatic test_branch;
    int pulses;
    logic [7:0] last_out;
    do_reset();
    prog_mem[0] = 12'h100; prog_mem[1] = 12'hB04; prog_mem[2] = 12'hE00; prog_mem[3] = 12'hE00;
    prog_mem[4] = 12'h101; prog_mem[5] = 12'hB00; prog_mem[6] = 12'hF00;
    load_prog(7);
    run_to_halt(60, pulses, last_out);
    n_vec++; if (pulses !== 0) begin n_err++; $display("FAIL br_out_pulses: got %0d want 0", pulses); end
    n_vec++; if (pc_dbg !== 4'd6) begin n_err++; $display("FAIL br_pc: got %0d want 6", pc_dbg); end
    n_vec++; if (dut.acc_q !== 8'h01) begin n_err++; $display("FAIL br_acc: got %h want 01", dut.acc_q); end
  endtask

  task automatic test_load_toggle;
    logic       vseq [5];
    logic [11:0] dseq [5];
    vseq[0] = 1; vseq[1] = 0; vseq[2] = 1; vseq[3] = 0; vseq[4] = 1;
    dseq[0] = 12'h111; dseq[1] = 12'hBAD; dseq[2] = 12'h222; dseq[3] = 12'hBAD; dseq[4] = 12'h333;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      prog_if.prog_valid = vseq[i];
      prog_if.prog_data  = dseq[i];
      prog_if.prog_last  = (i == 4);
      n_vec++; if (prog_if.prog_ready !== 1'b1) begin n_err++; $display("FAIL tog_ready_%0d: got %0b want 1", i, prog_if.prog_ready); end
      tick();
    end
    prog_if.prog_last = 1'b0;
    n_vec++; if (prog_if.prog_ready !== 1'b0) begin n_err++; $display("FAIL tog_ready_fall: got %0b want 0", prog_if.prog_ready); end
    prog_if.prog_data = 12'hBAD;
    tick();
    prog_if.prog_valid = 1'b0;
    n_vec++; if (dut.pmem_q[0] !== 12'h111) begin n_err++; $display("FAIL tog_pmem0: got %h want 111", dut.pmem_q[0]); end
    n_vec++; if (dut.pmem_q[1] !== 12'h222) begin n_err++; $display("FAIL tog_pmem1: got %h want 222", dut.pmem_q[1]); end
    n_vec++; if (dut.pmem_q[2] !== 12'h333) begin n_err++; $display("FAIL tog_pmem2: got %h want 333", dut.pmem_q[2]); end
    n_vec++; if (dut.pmem_q[3] !== 12'hE00) begin n_err++; $display("FAIL tog_pmem3_kept: got %h want e00", dut.pmem_q[3]); end
  endtask

  task automatic test_full_load;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      prog_if.prog_valid = 1'b1;
      prog_if.prog_data  = 12'h000;
      prog_if.prog_last  = 1'b0;
      n_vec++; if (prog_if.prog_ready !== 1'b1) begin n_err++; $display("FAIL full_ready_%0d: got %0b want 1", i, prog_if.prog_ready); end
      tick();
    end
    prog_if.prog_valid = 1'b0;
    n_vec++; if (prog_if.prog_ready !== 1'b0) begin n_err++; $display("FAIL full_ready_fall: got %0b want 0", prog_if.prog_ready); end
    n_vec++; if (pc_dbg !== 4'd0) begin n_err++; $display("FAIL full_pc0: got %0d want 0", pc_dbg); end
    for (int k = 1; k <= 17; k++) begin
      tick(); tick(); tick();
      n_vec++; if (pc_dbg !== 4'(k % 16)) begin n_err++; $display("FAIL full_pc_%0d: got %0d want %0d", k, pc_dbg, k % 16); end
      n_vec++; if (halted !== 1'b0) begin n_err++; $display("FAIL full_halted_%0d: got %0b want 0", k, halted); end
    end
  endtask

  task automatic test_reset_st;
    do_reset();
    prog_mem[0] = 12'h111; prog_mem[1] = 12'h302; prog_mem[2] = 12'h13C;
    prog_mem[3] = 12'h302; prog_mem[4] = 12'hF00;
    load_prog(5);
    for (int i = 0; i < 11; i++) tick();
    n_vec++; if (dut.state_q !== 3'd3) begin n_err++; $display("FAIL rst_st_in_exec: state %0d want 3", dut.state_q); end
    n_vec++; if (dut.acc_q !== 8'h3C) begin n_err++; $display("FAIL rst_st_acc_pre: got %h want 3c", dut.acc_q); end
    rst = 1'b0;
    tick();
    n_vec++; if (dut.dmem_q[2] !== 8'h11) begin n_err++; $display("FAIL rst_st_dmem2: got %h want 11", dut.dmem_q[2]); end
    n_vec++; if (dut.acc_q !== 8'h00) begin n_err++; $display("FAIL rst_st_acc: got %h want 00", dut.acc_q); end
    n_vec++; if (dut.state_q !== 3'd0) begin n_err++; $display("FAIL rst_st_state: got %0d want 0", dut.state_q); end
    n_vec++; if (pc_dbg !== 4'd0) begin n_err++; $display("FAIL rst_st_pc: got %0d want 0", pc_dbg); end
    rst = 1'b1;
    #1;
    n_vec++; if (prog_if.prog_ready !== 1'b1) begin n_err++; $display("FAIL rst_st_ready: got %0b want 1", prog_if.prog_ready); end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_store_out();
    test_branch();
    test_load_toggle();
    test_full_load();
    test_reset_st();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
